// File: rtl/ext_irq_ctrl_if.sv
// Register bus and CPU interrupt handshake between the core and ext_irq_ctrl.
interface ext_irq_ctrl_if #(
    parameter int VEC_W = 5
) ();
    logic             reg_we;
    logic             reg_re;
    logic [1:0]       reg_addr;
    logic [31:0]      reg_wdata;
    logic [31:0]      reg_rdata;
    logic             irq_req;
    logic [VEC_W-1:0] irq_vec;
    logic             irq_ack;
    logic             irq_eoi;

    modport master (
        output reg_we, reg_re, reg_addr, reg_wdata, irq_ack, irq_eoi,
        input  reg_rdata, irq_req, irq_vec
    );

    modport slave (
        input  reg_we, reg_re, reg_addr, reg_wdata, irq_ack, irq_eoi,
        output reg_rdata, irq_req, irq_vec
    );
endinterface

// File: rtl/ext_irq_ctrl.sv
// External interrupt receiver: synchroniser, pending/enable regs, fixed-priority req/ack/eoi hand-off.
// Define EXT_IRQ_LEVEL_SEL_EN to add the per-line MODE register (level-sensitive lines).
//
// state | meaning
// IDLE  | no vector offered, waiting for PEND&EN
// REQ   | irq_req high, irq_vec frozen, waiting for ack
// SVC   | vector in service (INSV one-hot), waiting for eoi
module ext_irq_ctrl #(
    parameter int N_IRQ       = 31,
    parameter int SYNC_STAGES = 2,
    parameter int VEC_W       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] i_ext,
    ext_irq_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

    state_t           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d, win;
    logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [N_IRQ-1:0] sync_prev_q, synced, rise;
    logic [N_IRQ-1:0] en_q, pend_q, pend_d, insv_q, insv_d, cand;
    logic [31:0]      rdata_q, rd_mux;
    logic             unused_wdata;

`ifdef EXT_IRQ_LEVEL_SEL_EN
    logic [N_IRQ-1:0] mode_q;
`endif

    assign synced       = sync_q[SYNC_STAGES-1];
    assign rise         = synced & ~sync_prev_q;
    assign cand         = pend_q & en_q;
    assign unused_wdata = ^bus.reg_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            sync_prev_q <= '0;
        end else begin
            sync_q[0] <= i_ext;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            sync_prev_q <= synced;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            pend_q  <= '0;
            insv_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            pend_q  <= pend_d;
            insv_q  <= insv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        pend_d  = pend_q;
        insv_d  = insv_q;
        win     = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) win = VEC_W'(i);
        end
        if (bus.reg_we && bus.reg_addr == 2'd1) pend_d = pend_d & ~bus.reg_wdata[N_IRQ-1:0];
        case (state_q)
            IDLE: begin
                if (|cand) begin
                    state_d = REQ;
                    vec_d   = win;
                end
            end
            REQ: begin
                // withdrawal of the offered line takes precedence over a late ack
                if (!(pend_q[vec_q] && en_q[vec_q])) begin
                    state_d = IDLE;
                end else if (bus.irq_ack) begin
                    pend_d[vec_q] = 1'b0;
                    insv_d        = '0;
                    insv_d[vec_q] = 1'b1;
                    state_d       = SVC;
                end
            end
            SVC: begin
                if (bus.irq_eoi) begin
                    insv_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // set events applied last so they beat a same-cycle W1C or ack
        pend_d = pend_d | rise;
`ifdef EXT_IRQ_LEVEL_SEL_EN
        pend_d = (pend_d & ~mode_q) | (synced & mode_q);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= '0;
        end else if (bus.reg_we && bus.reg_addr == 2'd0) begin
            en_q <= bus.reg_wdata[N_IRQ-1:0];
        end
    end

`ifdef EXT_IRQ_LEVEL_SEL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0;
        end else if (bus.reg_we && bus.reg_addr == 2'd3) begin
            mode_q <= bus.reg_wdata[N_IRQ-1:0];
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (bus.reg_addr)
            2'd0: rd_mux[N_IRQ-1:0] = en_q;
            2'd1: rd_mux[N_IRQ-1:0] = pend_q;
            2'd2: rd_mux[N_IRQ-1:0] = insv_q;
`ifdef EXT_IRQ_LEVEL_SEL_EN
            2'd3: rd_mux[N_IRQ-1:0] = mode_q;
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (bus.reg_re) begin
            rdata_q <= rd_mux;
        end
    end

    assign bus.reg_rdata = rdata_q;
    assign bus.irq_req   = (state_q == REQ);
    assign bus.irq_vec   = vec_q;
endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Self-checking bench for ext_irq_ctrl: expected vectors queued at stimulus, popped on irq_req.
module tb_ext_irq_ctrl;
    localparam int N_IRQ = 31;
    localparam int SYNC  = 2;
    localparam int VEC_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_IRQ-1:0] i_ext = '0;
    int               checks = 0;
    int               errors = 0;
    int               sb[$];

    ext_irq_ctrl_if #(.VEC_W(VEC_W)) bus ();

    ext_irq_ctrl #(.N_IRQ(N_IRQ), .SYNC_STAGES(SYNC), .VEC_W(VEC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ext (i_ext),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic reg_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.reg_we = 1'b1; bus.reg_addr = addr; bus.reg_wdata = data;
        @(negedge clk);
        bus.reg_we = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.reg_re = 1'b1; bus.reg_addr = addr;
        @(negedge clk);
        bus.reg_re = 1'b0;
        data = bus.reg_rdata;
    endtask

    task automatic check_reg(input string name, input logic [1:0] addr, input logic [31:0] exp);
        logic [31:0] got;
        reg_read(addr, got);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
        end
    endtask

    task automatic wait_req(input string name, output bit ok);
        int n = 0;
        while (bus.irq_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.irq_req === 1'b1);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: irq_req timeout got %b required 1", name, bus.irq_req);
        end
    endtask

    task automatic service(input string name);
        bit ok;
        int exp;
        wait_req(name, ok);
        if (!ok) return;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected request vec %0d", name, bus.irq_vec);
            return;
        end
        exp = sb.pop_front();
        if (bus.irq_vec !== VEC_W'(exp)) begin
            errors++;
            $display("FAIL %s vec: got %0d required %0d", name, bus.irq_vec, exp);
        end
        bus.irq_ack = 1'b1;
        @(negedge clk);
        bus.irq_ack = 1'b0;
        checks++;
        if (bus.irq_req !== 1'b0) begin
            errors++;
            $display("FAIL %s req_after_ack: got %b required 0", name, bus.irq_req);
        end
        check_reg({name, " insv"}, 2'd2, 32'd1 << exp);
        bus.irq_eoi = 1'b1;
        @(negedge clk);
        bus.irq_eoi = 1'b0;
    endtask

    task automatic quiesce();
        i_ext = '0;
        repeat (4) @(negedge clk);
        reg_write(2'd0, 32'h0);
        reg_write(2'd1, 32'hFFFF_FFFF);
    endtask

    task automatic test_reset();
        bus.reg_we = 0; bus.reg_re = 0; bus.reg_addr = 0; bus.reg_wdata = 0;
        bus.irq_ack = 0; bus.irq_eoi = 0;
        #1;
        checks++;
        if (bus.irq_req !== 1'b0 || bus.irq_vec !== '0 || bus.reg_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b vec=%0d rdata=0x%08h required 0/0/0",
                     bus.irq_req, bus.irq_vec, bus.reg_rdata);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_reg("reset_en", 2'd0, 32'h0);
        check_reg("reset_pend", 2'd1, 32'h0);
        check_reg("reset_insv", 2'd2, 32'h0);
    endtask

    task automatic test_edge_latency();
        reg_write(2'd0, 32'h4);
        @(negedge clk);
        i_ext[2] = 1'b1;
        sb.push_back(2);
        repeat (SYNC + 1) @(negedge clk);
        checks++;
        if (bus.irq_req !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: irq_req got %b required 0", bus.irq_req);
        end
        @(negedge clk);
        checks++;
        if (bus.irq_req !== 1'b1) begin
            errors++;
            $display("FAIL latency_req: irq_req got %b required 1", bus.irq_req);
        end
        check_reg("latency_pend", 2'd1, 32'h4);
        service("latency");
        quiesce();
    endtask

    task automatic test_priority();
        reg_write(2'd0, 32'h106);
        @(negedge clk);
        i_ext[8] = 1'b1; i_ext[2] = 1'b1; i_ext[1] = 1'b1;
        sb.push_back(1); sb.push_back(2); sb.push_back(8);
        service("prio_a");
        service("prio_b");
        service("prio_c");
        repeat (5) @(negedge clk);
        checks++;
        if (bus.irq_req !== 1'b0) begin
            errors++;
            $display("FAIL prio_done: irq_req got %b required 0", bus.irq_req);
        end
        quiesce();
    endtask

    task automatic test_enable_late();
        @(negedge clk);
        i_ext[3] = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (bus.irq_req !== 1'b0) begin
            errors++;
            $display("FAIL late_masked: irq_req got %b required 0", bus.irq_req);
        end
        check_reg("late_pend", 2'd1, 32'h8);
        reg_write(2'd0, 32'h8);
        checks++;
        if (bus.irq_req !== 1'b0) begin
            errors++;
            $display("FAIL late_same_cycle: irq_req got %b required 0", bus.irq_req);
        end
        sb.push_back(3);
        @(negedge clk);
        checks++;
        if (bus.irq_req !== 1'b1) begin
            errors++;
            $display("FAIL late_req: irq_req got %b required 1", bus.irq_req);
        end
        service("late");
        quiesce();
    endtask

    task automatic test_cancel();
        bit ok;
        reg_write(2'd0, 32'h20);
        @(negedge clk);
        i_ext[5] = 1'b1;
        wait_req("cancel", ok);
        checks++;
        if (bus.irq_vec !== VEC_W'(5)) begin
            errors++;
            $display("FAIL cancel_vec: got %0d required 5", bus.irq_vec);
        end
        reg_write(2'd0, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.irq_req !== 1'b0) begin
            errors++;
            $display("FAIL cancel_drop: irq_req got %b required 0", bus.irq_req);
        end
        check_reg("cancel_pend", 2'd1, 32'h20);
        quiesce();
    endtask

    task automatic test_w1c_race();
        @(negedge clk);
        i_ext[4] = 1'b1;
        repeat (SYNC) @(negedge clk);
        bus.reg_we = 1'b1; bus.reg_addr = 2'd1; bus.reg_wdata = 32'h10;
        @(negedge clk);
        bus.reg_we = 1'b0;
        check_reg("w1c_race", 2'd1, 32'h10);
        reg_write(2'd1, 32'h10);
        check_reg("w1c_alone", 2'd1, 32'h0);
        quiesce();
    endtask

    task automatic test_regs();
        logic [31:0] got;
        reg_write(2'd0, 32'hFFFF_FFFF);
        check_reg("en_upper_bit", 2'd0, 32'h7FFF_FFFF);
        reg_write(2'd2, 32'hFF);
        check_reg("insv_ro", 2'd2, 32'h0);
        reg_write(2'd3, 32'hFF);
        check_reg("mode_absent", 2'd3, 32'h0);
        @(negedge clk);
        bus.reg_we = 1'b1; bus.reg_re = 1'b1; bus.reg_addr = 2'd0; bus.reg_wdata = 32'h5;
        @(negedge clk);
        bus.reg_we = 1'b0; bus.reg_re = 1'b0;
        got = bus.reg_rdata;
        checks++;
        if (got !== 32'h7FFF_FFFF) begin
            errors++;
            $display("FAIL rw_same_cycle: got 0x%08h required 0x7fffffff", got);
        end
        check_reg("rw_after", 2'd0, 32'h5);
        quiesce();
    endtask

    task automatic test_async_reset();
        bit ok;
        int exp;
        reg_write(2'd0, 32'h2);
        @(negedge clk);
        i_ext[1] = 1'b1;
        sb.push_back(1);
        wait_req("arst", ok);
        exp = sb.pop_front();
        checks++;
        if (bus.irq_vec !== VEC_W'(exp)) begin
            errors++;
            $display("FAIL arst_vec: got %0d required %0d", bus.irq_vec, exp);
        end
        bus.irq_ack = 1'b1;
        @(negedge clk);
        bus.irq_ack = 1'b0;
        check_reg("arst_insv", 2'd2, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.irq_req !== 1'b0 || bus.irq_vec !== '0 || bus.reg_rdata !== 32'h0) begin
            errors++;
            $display("FAIL arst_immediate: got req=%b vec=%0d rdata=0x%08h required 0/0/0",
                     bus.irq_req, bus.irq_vec, bus.reg_rdata);
        end
        i_ext = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_reg("arst_en", 2'd0, 32'h0);
        check_reg("arst_pend", 2'd1, 32'h0);
        check_reg("arst_insv_clr", 2'd2, 32'h0);
    endtask

    initial begin
        test_reset();
        test_edge_latency();
        test_priority();
        test_enable_late();
        test_cancel();
        test_w1c_race();
        test_regs();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
